ay_bus_seq: RTL and testbench

- Clocked sequencer that turns host register read/write requests into correctly timed AY-3-8910/YM2149 bus cycles (BDIR/BC1/BC2 plus data bus).
- Supports several PSG chips (TurboSound-style) with per-chip control strobes and a shared data bus.
- Sits between the BK CPU-side register decode and the PSG pins; replaces fixed strobe-derived gating with programmable phase timing.

---
 rtl/ay_pkg.sv | 25 ++
 rtl/ay_phase_timer.sv | 29 ++
 rtl/ay_bus_seq.sv | 189 ++++++++++++++++++
 tb/tb_ay_bus_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ay_pkg.sv
// Shared types and constants for the AY-3-8910/YM2149 bus sequencer.
// Bus codes are {bdir, bc1} pairs; BC2 is held high by the top level.
package ay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_GAP,
    ST_WDATA,
    ST_RDATA,
    ST_HOLD
  } ay_state_t;

  localparam logic [1:0] AY_INACT = 2'b00;
  localparam logic [1:0] AY_LATCH = 2'b11;
  localparam logic [1:0] AY_WRITE = 2'b10;
  localparam logic [1:0] AY_READ  = 2'b01;

  localparam logic [7:0] AY_RST_DATA = 8'hFF;

  function automatic int ay_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ay_phase_timer.sv
// Loadable down-counter shared by every bus phase. Load the phase length
// minus one; o_done is high on the last clock of the phase. Never wraps.
module ay_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/ay_bus_seq.sv
// Host-request to AY/YM PSG bus-cycle sequencer for up to four chips.
// Optional per-chip latched-address cache: define AY_ADDR_CACHE_EN.
module ay_bus_seq
  import ay_pkg::*;
#(
  parameter int NUM_CHIPS = 2,
  parameter int LATCH_CYC = 2,
  parameter int GAP_CYC   = 1,
  parameter int WR_CYC    = 3,
  parameter int RD_CYC    = 3,
  parameter int HOLD_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_chip,
  input  logic [3:0]           req_reg,
  input  logic [7:0]           req_wdata,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic [NUM_CHIPS-1:0] ay_bdir,
  output logic [NUM_CHIPS-1:0] ay_bc1,
  output logic [NUM_CHIPS-1:0] ay_bc2,
  output logic [7:0]           da_out,
  output logic                 da_oe,
  input  logic [7:0]           da_in
);

  localparam int MAX_PHASE = ay_max(ay_max(ay_max(LATCH_CYC, GAP_CYC),
                                           ay_max(WR_CYC, RD_CYC)), HOLD_CYC);
  localparam int CW = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

  localparam logic [CW-1:0] L_LATCH = CW'(LATCH_CYC - 1);
  localparam logic [CW-1:0] L_GAP   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] L_WR    = CW'(WR_CYC - 1);
  localparam logic [CW-1:0] L_RD    = CW'(RD_CYC - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(HOLD_CYC - 1);

  ay_state_t     r_state, w_next;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_done;
  logic          w_accept, w_bad, w_hit;
  logic [1:0]    w_code;

  logic          r_write, r_err;
  logic [1:0]    r_chip;
  logic [3:0]    r_reg;
  logic [7:0]    r_wdata, r_rdata;

  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_bad     = (int'(req_chip) >= NUM_CHIPS);

  ay_phase_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

`ifdef AY_ADDR_CACHE_EN
  logic [3:0] r_cache_vld;
  logic [3:0] r_cache_reg [4];

  assign w_hit = r_cache_vld[req_chip] && (r_cache_reg[req_chip] == req_reg);

  // NOTE: only the valid bits need reset; stale register numbers behind a
  // cleared valid bit are never compared, so the storage is left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cache_vld <= '0;
    end else if (w_accept && !w_bad && !w_hit) begin
      r_cache_vld[req_chip] <= 1'b1;
      r_cache_reg[req_chip] <= req_reg;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_chip  <= '0;
      r_reg   <= '0;
      r_wdata <= '0;
      r_rdata <= AY_RST_DATA;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= req_write;
        r_err   <= w_bad;
        r_chip  <= req_chip;
        r_reg   <= req_reg;
        r_wdata <= req_wdata;
      end
      if (r_state == ST_RDATA && w_done) r_rdata <= da_in;
    end
  end

  // Every state transition reloads the timer with the new phase length.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    unique case (r_state)
      ST_IDLE: if (w_accept) begin
        w_load = 1'b1;
        if (w_bad) begin
          w_next = ST_HOLD;
        end else if (w_hit) begin
          w_next     = req_write ? ST_WDATA : ST_RDATA;
          w_load_val = req_write ? L_WR : L_RD;
        end else begin
          w_next     = ST_LATCH;
          w_load_val = L_LATCH;
        end
      end
      ST_LATCH: if (w_done) begin
        w_next     = ST_GAP;
        w_load     = 1'b1;
        w_load_val = L_GAP;
      end
      ST_GAP: if (w_done) begin
        w_next     = r_write ? ST_WDATA : ST_RDATA;
        w_load     = 1'b1;
        w_load_val = r_write ? L_WR : L_RD;
      end
      ST_WDATA, ST_RDATA: if (w_done) begin
        w_next     = ST_HOLD;
        w_load     = 1'b1;
        w_load_val = L_HOLD;
      end
      ST_HOLD: if (w_done) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    w_code    = AY_INACT;
    da_oe     = 1'b0;
    da_out    = 8'h00;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = AY_RST_DATA;
    unique case (r_state)
      ST_LATCH: begin
        w_code = AY_LATCH;
        da_oe  = 1'b1;
        da_out = {4'h0, r_reg};
      end
      ST_WDATA: begin
        w_code = AY_WRITE;
        da_oe  = 1'b1;
        da_out = r_wdata;
      end
      ST_RDATA: w_code = AY_READ;
      ST_HOLD: begin
        if (r_write && !r_err) begin
          da_oe  = 1'b1;
          da_out = r_wdata;
        end
        if (w_done) begin
          rsp_valid = 1'b1;
          rsp_err   = r_err;
          rsp_rdata = (r_write || r_err) ? AY_RST_DATA : r_rdata;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CHIPS; i++) begin
      ay_bdir[i] = w_code[1] && (r_chip == 2'(i));
      ay_bc1[i]  = w_code[0] && (r_chip == 2'(i));
      ay_bc2[i]  = 1'b1;
    end
  end

endmodule

// File: tb/tb_ay_bus_seq.sv
// Self-checking bench for ay_bus_seq: directed latency/data checks plus
// randomized traffic compared every cycle against a phase-schedule model.
module tb_ay_bus_seq;

  localparam int NUM_CHIPS = 2;
  localparam int LATCH_CYC = 2;
  localparam int GAP_CYC   = 1;
  localparam int WR_CYC    = 3;
  localparam int RD_CYC    = 3;
  localparam int HOLD_CYC  = 1;

`ifdef AY_ADDR_CACHE_EN
  localparam int LAT_REPEAT = 4;
`else
  localparam int LAT_REPEAT = 7;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic                 req_write = 1'b0;
  logic [1:0]           req_chip = '0;
  logic [3:0]           req_reg = '0;
  logic [7:0]           req_wdata = '0;
  logic                 rsp_valid;
  logic [7:0]           rsp_rdata;
  logic                 rsp_err;
  logic [NUM_CHIPS-1:0] ay_bdir, ay_bc1, ay_bc2;
  logic [7:0]           da_out;
  logic                 da_oe;
  logic [7:0]           da_in = '0;

  ay_bus_seq #(
    .NUM_CHIPS(NUM_CHIPS), .LATCH_CYC(LATCH_CYC), .GAP_CYC(GAP_CYC),
    .WR_CYC(WR_CYC), .RD_CYC(RD_CYC), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_chip(req_chip), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ay_bdir(ay_bdir), .ay_bc1(ay_bc1), .ay_bc2(ay_bc2),
    .da_out(da_out), .da_oe(da_oe), .da_in(da_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One expected bus cycle; code is {bdir,bc1} on the target chip.
  typedef struct {
    logic [1:0] code;
    int         chip;
    logic       oe;
    logic [7:0] dout;
    logic       rsp;
    logic       err;
    logic       use_rd;
    logic       sample;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit   cur_idle;
  bit   chk_en = 1'b0;
  logic [7:0] m_rd = 8'hFF;
  logic [NUM_CHIPS-1:0] ev_bdir, ev_bc1;
  bit   m_vld[4];
  logic [3:0] m_reg[4];

  function automatic exp_t mk(input logic [1:0] code, input int chip, input logic oe,
                              input logic [7:0] dout);
    exp_t r;
    r.code = code; r.chip = chip; r.oe = oe; r.dout = dout;
    r.rsp = 1'b0; r.err = 1'b0; r.use_rd = 1'b0; r.sample = 1'b0;
    return r;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
  endtask

  task automatic push_req(input logic w, input int chip, input logic [3:0] rg,
                          input logic [7:0] wd);
    exp_t r;
    bit hit = 1'b0;
    if (chip >= NUM_CHIPS) begin
      r = mk(2'b00, 0, 1'b0, 8'h00);
      r.rsp = 1'b1; r.err = 1'b1;
      q.push_back(r);
      return;
    end
`ifdef AY_ADDR_CACHE_EN
    hit = m_vld[chip] && (m_reg[chip] == rg);
    m_vld[chip] = 1'b1;
    m_reg[chip] = rg;
`endif
    if (!hit) begin
      for (int i = 0; i < LATCH_CYC; i++) q.push_back(mk(2'b11, chip, 1'b1, {4'h0, rg}));
      for (int i = 0; i < GAP_CYC; i++)   q.push_back(mk(2'b00, chip, 1'b0, 8'h00));
    end
    if (w) begin
      for (int i = 0; i < WR_CYC; i++) q.push_back(mk(2'b10, chip, 1'b1, wd));
    end else begin
      for (int i = 0; i < RD_CYC; i++) begin
        r = mk(2'b01, chip, 1'b0, 8'h00);
        r.sample = (i == RD_CYC - 1);
        q.push_back(r);
      end
    end
    for (int i = 0; i < HOLD_CYC; i++) begin
      r = mk(2'b00, chip, w, wd);
      if (i == HOLD_CYC - 1) begin
        r.rsp = 1'b1; r.use_rd = !w;
      end
      q.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cur_idle = (q.size() == 0);
      if (cur_idle) e = mk(2'b00, 0, 1'b0, 8'h00);
      else          e = q.pop_front();
      if (e.sample) m_rd = da_in;
      for (int i = 0; i < NUM_CHIPS; i++) begin
        ev_bdir[i] = e.code[1] && (e.chip == i);
        ev_bc1[i]  = e.code[0] && (e.chip == i);
      end
      check("ready", 32'(req_ready), 32'(cur_idle));
      check("bdir", 32'(ay_bdir), 32'(ev_bdir));
      check("bc1", 32'(ay_bc1), 32'(ev_bc1));
      check("bc2", 32'(ay_bc2), 32'({NUM_CHIPS{1'b1}}));
      check("da_oe", 32'(da_oe), 32'(e.oe));
      if (e.oe) check("da_out", 32'(da_out), 32'(e.dout));
      check("rsp_valid", 32'(rsp_valid), 32'(e.rsp));
      if (e.rsp) begin
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.use_rd ? m_rd : 8'hFF));
      end
      if (rst) model_clear();
      else if (cur_idle && req_valid) push_req(req_write, int'(req_chip), req_reg, req_wdata);
    end
  end

  // Issue one request and measure clocks from the accept clock to rsp_valid.
  task automatic direct(input string name, input logic w, input logic [1:0] chip,
                        input logic [3:0] rg, input logic [7:0] wd, input logic [7:0] rd,
                        input int exp_lat, input logic [7:0] exp_rdata, input logic exp_err);
    int lat;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_chip = chip; req_reg = rg;
    req_wdata = wd; da_in = rd;
    for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
    check({name, "_err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  initial begin
    int lat;
    bit low_ok;
    model_clear();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_bdir", 32'(ay_bdir), 32'd0);
    check("rst_bc2", 32'(ay_bc2), 32'(2'b11));
    check("rst_da_out", 32'(da_out), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'hFF);
    @(posedge clk); #1;
    rst = 1'b0;

    direct("wr_c0r7", 1'b1, 2'd0, 4'd7, 8'h3E, 8'h00, 7, 8'hFF, 1'b0);
    direct("wr_c0r7_again", 1'b1, 2'd0, 4'd7, 8'h3E, 8'h00, LAT_REPEAT, 8'hFF, 1'b0);
    direct("rd_c1r14", 1'b0, 2'd1, 4'd14, 8'h00, 8'hA5, 7, 8'hA5, 1'b0);
    direct("bad_chip", 1'b1, 2'd3, 4'd2, 8'h11, 8'h00, 1, 8'hFF, 1'b1);

    // Back-to-back writes with req_valid held high.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_chip = 2'd1; req_reg = 4'd1; req_wdata = 8'h5A;
    for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    req_reg = 4'd2; req_wdata = 8'hC3;
    low_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) low_ok = 1'b0;
      if (rsp_valid) break;
    end
    check("b2b_ready_low", 32'(low_ok), 32'd1);
    @(negedge clk);
    check("b2b_second_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    check("b2b_second_lat", 32'(lat), 32'd7);

    // Reset in the first WDATA clock drops the request.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_chip = 2'd0; req_reg = 4'd5; req_wdata = 8'h77;
    for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_wdata_bdir", 32'(ay_bdir), 32'd1);
    @(negedge clk);
    check("rst_mid_bdir", 32'(ay_bdir), 32'd0);
    check("rst_mid_bc1", 32'(ay_bc1), 32'd0);
    check("rst_mid_oe", 32'(da_oe), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    direct("wr_after_rst", 1'b1, 2'd0, 4'd7, 8'h3E, 8'h00, 7, 8'hFF, 1'b0);

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 399) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = 1'($urandom);
      req_chip  = 2'($urandom_range(0, 3));
      req_reg   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
      req_wdata = 8'($urandom);
      da_in     = 8'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (30) @(posedge clk);
    check("drain_idle", 32'(q.size()), 32'd0);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
